fetch_pc_unit: RTL and testbench

//   Instruction-fetch stage of the single-cycle MIPS CPU. Sits directly upstream of the

---
 rtl/fetch_pc_unit.sv | 117 +++++++++++
 tb/tb_fetch_pc_unit.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_pc_unit.sv
// Instruction-fetch stage: PC register, ROM word addressing, next-PC selection
// (sequential / branch / jump), NOP gating outside RUN, out-of-range fetch trap
// and a saturating retired-instruction counter.
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned ADDR_W    = 5,
  parameter int unsigned ROM_DEPTH = 21,
  parameter int unsigned CNT_W     = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              stall,
  input  logic              br_taken,
  input  logic [15:0]       br_offset,
  input  logic              jmp_taken,
  input  logic [25:0]       jmp_index,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [31:0]       rom_inst,
  output logic [31:0]       inst,
  output logic [31:0]       pc,
  output logic [31:0]       pc_plus4,
  output logic              inst_valid,
  output logic              fault,
  output logic [CNT_W-1:0]  retired
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [31:0]       pc_nxt;
  logic              fault_nxt;
  logic [CNT_W-1:0]  retired_nxt;

  logic [31:0]       br_target;
  logic [31:0]       jmp_target;
  logic [31:0]       next_pc;
  logic [31:0]       next_off;
  logic              next_bad;
  logic [CNT_W-1:0]  retired_inc;

  // Sequential address, branch and jump targets; all arithmetic wraps mod 2^32.
  assign pc_plus4   = pc + 32'd4;
  assign br_target  = pc_plus4 + {{14{br_offset[15]}}, br_offset, 2'b00};
  assign jmp_target = {pc_plus4[31:28], jmp_index, 2'b00};

  // Jump has priority over branch when decode asserts both.
  always_comb begin
    next_pc = pc_plus4;
    if (jmp_taken)
      next_pc = jmp_target;
    else if (br_taken)
      next_pc = br_target;
  end

  // Word index of the candidate PC relative to ROM base; anything past the
  // last valid word (including wrap below the base) is a fetch fault.
  assign next_off = next_pc - RESET_PC;
  assign next_bad = (next_off >> 2) >= 32'(ROM_DEPTH);

  // Counter sticks at all-ones instead of wrapping.
  assign retired_inc = (&retired) ? retired : retired + CNT_W'(1);

  // ROM is addressed straight from the PC; fetched word is a NOP unless running.
  assign rom_addr   = ADDR_W'((pc - RESET_PC) >> 2);
  assign inst_valid = (state == RUN);
  assign inst       = inst_valid ? rom_inst : '0;

  // Next-state and commit decision; every register holds by default.
  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc;
    fault_nxt   = fault;
    retired_nxt = retired;
    unique case (state)
      BOOT: begin
        state_nxt = RUN;
      end
      RUN: begin
        if (!stall) begin
          pc_nxt      = next_pc;
          retired_nxt = retired_inc;
          if (next_bad) begin
            state_nxt = FAULT;
            fault_nxt = 1'b1;
          end
        end
      end
      FAULT: begin
        state_nxt = FAULT;
      end
      default: begin
        state_nxt = BOOT;
      end
    endcase
  end

  // State, PC, fault flag and counter registers with async active-low reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= BOOT;
      pc      <= RESET_PC;
      fault   <= 1'b0;
      retired <= '0;
    end else begin
      state   <= state_nxt;
      pc      <= pc_nxt;
      fault   <= fault_nxt;
      retired <= retired_nxt;
    end
  end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Randomized scoreboard bench for fetch_pc_unit: a behavioural model pushes the
// expected per-cycle outputs, a separate monitor pops and compares them.
module tb_fetch_pc_unit;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        stall = 1'b0;
  logic        br_taken = 1'b0;
  logic [15:0] br_offset = '0;
  logic        jmp_taken = 1'b0;
  logic [25:0] jmp_index = '0;

  logic [4:0]  rom_addr, rom_addr2;
  logic [31:0] rom_inst, rom_inst2;
  logic [31:0] inst, inst2, pc, pc2, pc_plus4, pc_plus42;
  logic        inst_valid, inst_valid2, fault, fault2;
  logic [31:0] retired;
  logic [2:0]  retired2;

  logic [31:0] rom [32];

  assign rom_inst  = rom[rom_addr];
  assign rom_inst2 = rom[rom_addr2];

  fetch_pc_unit dut (
    .clk(clk), .resetn(resetn), .stall(stall), .br_taken(br_taken),
    .br_offset(br_offset), .jmp_taken(jmp_taken), .jmp_index(jmp_index),
    .rom_addr(rom_addr), .rom_inst(rom_inst), .inst(inst), .pc(pc),
    .pc_plus4(pc_plus4), .inst_valid(inst_valid), .fault(fault), .retired(retired)
  );

  fetch_pc_unit #(.CNT_W(3)) dut_sat (
    .clk(clk), .resetn(resetn), .stall(stall), .br_taken(br_taken),
    .br_offset(br_offset), .jmp_taken(jmp_taken), .jmp_index(jmp_index),
    .rom_addr(rom_addr2), .rom_inst(rom_inst2), .inst(inst2), .pc(pc2),
    .pc_plus4(pc_plus42), .inst_valid(inst_valid2), .fault(fault2), .retired(retired2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [4:0]  ra;
    logic [31:0] inst;
    logic        v;
    logic        f;
    logic [31:0] ret;
    logic [2:0]  rs;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;

  // Reference model: PC, state, and the two counters.
  typedef enum {M_BOOT, M_RUN, M_FAULT} mstate_t;
  mstate_t     m_state;
  logic [31:0] m_pc;
  longint      m_ret;
  int          m_rs;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: compare DUT outputs mid-cycle against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("pc", pc, e.pc);
        chk("pc_plus4", pc_plus4, e.pc4);
        chk("rom_addr", 32'(rom_addr), 32'(e.ra));
        chk("inst", inst, e.inst);
        chk("inst_valid", 32'(inst_valid), 32'(e.v));
        chk("fault", 32'(fault), 32'(e.f));
        chk("retired", retired, e.ret);
        chk("sat_pc", pc2, e.pc);
        chk("sat_inst", inst2, e.inst);
        chk("sat_fault", 32'(fault2), 32'(e.f));
        chk("sat_valid", 32'(inst_valid2), 32'(e.v));
        chk("sat_pc_plus4", pc_plus42, e.pc4);
        chk("sat_rom_addr", 32'(rom_addr2), 32'(e.ra));
        chk("sat_retired", 32'(retired2), 32'(e.rs));
      end
    end
  end

  function automatic exp_t expect_now();
    exp_t e;
    e.pc   = m_pc;
    e.pc4  = m_pc + 32'd4;
    e.ra   = 5'((m_pc / 4) % 32);
    e.v    = (m_state == M_RUN);
    e.inst = e.v ? rom[e.ra] : 32'h0;
    e.f    = (m_state == M_FAULT);
    e.ret  = 32'(m_ret);
    e.rs   = 3'(m_rs);
    return e;
  endfunction

  task automatic model_reset();
    m_state = M_BOOT;
    m_pc    = 32'h0;
    m_ret   = 0;
    m_rs    = 0;
  endtask

  task automatic model_tick(input logic st, input logic br, input logic [15:0] off,
                            input logic jm, input logic [25:0] ji);
    logic [31:0] seq, np;
    case (m_state)
      M_BOOT: m_state = M_RUN;
      M_RUN: if (!st) begin
        seq = m_pc + 32'd4;
        if (jm)      np = (seq & 32'hF000_0000) | (32'(ji) * 32'd4);
        else if (br) np = seq + 32'(int'($signed(off)) * 4);
        else         np = seq;
        if (m_ret < 64'hFFFF_FFFF) m_ret++;
        if (m_rs < 7) m_rs++;
        m_pc = np;
        if (np / 4 >= 21) m_state = M_FAULT;
      end
      default: ;
    endcase
  endtask

  task automatic step(input logic st, input logic br, input logic [15:0] off,
                      input logic jm, input logic [25:0] ji);
    @(negedge clk);
    stall = st; br_taken = br; br_offset = off; jmp_taken = jm; jmp_index = ji;
    q.push_back(expect_now());
    @(posedge clk);
    model_tick(st, br, off, jm, ji);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    resetn = 1'b0;
    stall = 1'b0; br_taken = 1'b0; jmp_taken = 1'b0;
    model_reset();
    q.push_back(expect_now());
    @(negedge clk);
    resetn = 1'b1;
    q.push_back(expect_now());
    @(posedge clk);
    model_tick(1'b0, 1'b0, 16'h0, 1'b0, 26'h0);
  endtask

  task automatic run_seq_to(input logic [31:0] target);
    for (int i = 0; i < 64 && m_pc != target; i++)
      step(1'b0, 1'b0, 16'h0, 1'b0, 26'h0);
  endtask

  initial begin
    int fault_cycles;
    for (int i = 0; i < 32; i++) rom[i] = $urandom;
    model_reset();

    // Sequential fetch from reset; long enough to saturate the 3-bit counter.
    apply_reset();
    run_seq_to(32'h18);
    // Branch +6 words from 0x18.
    step(1'b0, 1'b1, 16'h0006, 1'b0, 26'h0);
    step(1'b0, 1'b0, 16'h0, 1'b0, 26'h0);

    // Jump beats branch from 0x2C.
    apply_reset();
    run_seq_to(32'h2C);
    step(1'b0, 1'b1, 16'h0003, 1'b1, 26'h10);
    step(1'b0, 1'b0, 16'h0, 1'b0, 26'h0);

    // Three-cycle stall at 0x0C, with branch/jump noise that must be ignored.
    apply_reset();
    run_seq_to(32'h0C);
    step(1'b1, 1'b1, 16'h0004, 1'b0, 26'h0);
    step(1'b1, 1'b0, 16'h0, 1'b1, 26'h3);
    step(1'b1, 1'b0, 16'h0, 1'b0, 26'h0);
    step(1'b0, 1'b0, 16'h0, 1'b0, 26'h0);

    // Last valid word then sequential overrun into FAULT, then frozen.
    apply_reset();
    step(1'b0, 1'b0, 16'h0, 1'b1, 26'h14);
    step(1'b0, 1'b0, 16'h0, 1'b0, 26'h0);
    step(1'b0, 1'b1, 16'hFFF0, 1'b0, 26'h0);
    step(1'b0, 1'b0, 16'h0, 1'b1, 26'h1);
    step(1'b1, 1'b0, 16'h0, 1'b0, 26'h0);
    apply_reset();
    step(1'b0, 1'b0, 16'h0, 1'b0, 26'h0);

    // Randomized traffic; recover from faults with a reset pulse.
    fault_cycles = 0;
    for (int n = 0; n < 400; n++) begin
      logic st, br, jm;
      logic [15:0] off;
      logic [25:0] ji;
      st  = ($urandom_range(0, 3) == 0);
      br  = ($urandom_range(0, 9) < 3);
      jm  = ($urandom_range(0, 9) == 0);
      off = 16'($signed($urandom_range(0, 16)) - 8);
      ji  = 26'($urandom_range(0, 24));
      if (m_state == M_FAULT) begin
        fault_cycles++;
        if (fault_cycles > 3) begin
          apply_reset();
          fault_cycles = 0;
          continue;
        end
      end
      step(st, br, off, jm, ji);
    end

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 8 && q.size() > 0; i++) @(posedge clk);
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain actual=%0d required=0", q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
